cmp_mode_ctrl: RTL and testbench

Mode controller for the 4-bit magnitude comparator display. It debounces the three raw mode buttons and turns them into a latched mode (EQ / LT / GT / IDLE), with an optional auto-cycle. It drives a clean one-hot select into the comparator's display encoder in place of raw `b1/b2/b3`. It also generates the 2-bit digit-scan index that multiplexes the four display digits.

---
 rtl/cmp_mode_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 45 ++++
 rtl/cmp_mode_ctrl.sv | 114 +++++++++++
 tb/tb_cmp_mode_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_mode_pkg.sv
// rtl/cmp_mode_pkg.sv - mode encoding and one-hot select decode shared with the display encoder
package cmp_mode_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_EQ   = 2'b01,
        MODE_LT   = 2'b10,
        MODE_GT   = 2'b11
    } mode_e;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_EQ   = 3'b001;
    localparam logic [2:0] SEL_LT   = 3'b010;
    localparam logic [2:0] SEL_GT   = 3'b100;

    // One-hot ordering is {GT,LT,EQ}; IDLE selects nothing.
    function automatic logic [2:0] mode_sel(input mode_e m);
        case (m)
            MODE_EQ: return SEL_EQ;
            MODE_LT: return SEL_LT;
            MODE_GT: return SEL_GT;
            default: return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, stability counter and press pulse for one raw button
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta     <= 1'b0;
            sync     <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            press    <= 1'b0;
            cnt      <= '0;
        end else begin
            meta     <= btn;
            sync     <= meta;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            // Any cycle where sync agrees with the accepted level restarts the count.
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cmp_mode_ctrl.sv
// rtl/cmp_mode_ctrl.sv - debounced mode FSM with auto-cycle and digit-scan counter for the comparator display
module cmp_mode_ctrl
    import cmp_mode_pkg::*;
#(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int AUTO_CYCLES = 50_000_000,
    parameter int SCAN_BITS   = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       b1,
    input  logic       b2,
    input  logic       b3,
    input  logic       auto_en,
    output logic [2:0] sel,
    output logic [1:0] mode,
    output logic       mode_stb,
    output logic [1:0] digit
);

    localparam int AW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CYCLES - 1);

    logic p_eq;
    logic p_lt;
    logic p_gt;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_eq (
        .clk   (clk),
        .reset (reset),
        .btn   (b1),
        .press (p_eq)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lt (
        .clk   (clk),
        .reset (reset),
        .btn   (b2),
        .press (p_lt)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_gt (
        .clk   (clk),
        .reset (reset),
        .btn   (b3),
        .press (p_gt)
    );

    mode_e           state;
    mode_e           nxt;
    mode_e           tgt;
    logic            one_press;
    logic [AW-1:0]   auto_cnt;
    logic [SCAN_BITS-1:0] scan_cnt;

    always_comb begin
        nxt       = state;
        tgt       = state;
        one_press = 1'b0;
        if (auto_en) begin
            // Presses are discarded entirely while auto-cycling.
            if (state == MODE_IDLE) begin
                nxt = MODE_EQ;
            end else if (auto_cnt == AUTO_LAST) begin
                case (state)
                    MODE_EQ: nxt = MODE_LT;
                    MODE_LT: nxt = MODE_GT;
                    default: nxt = MODE_EQ;
                endcase
            end
        end else begin
            case ({p_gt, p_lt, p_eq})
                3'b001: begin tgt = MODE_EQ; one_press = 1'b1; end
                3'b010: begin tgt = MODE_LT; one_press = 1'b1; end
                3'b100: begin tgt = MODE_GT; one_press = 1'b1; end
                default: begin tgt = state; one_press = 1'b0; end
            endcase
            if (one_press) begin
                nxt = (tgt == state) ? MODE_IDLE : tgt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= MODE_IDLE;
            mode     <= MODE_IDLE;
            sel      <= SEL_NONE;
            mode_stb <= 1'b0;
            auto_cnt <= '0;
        end else begin
            state    <= nxt;
            mode     <= nxt;
            sel      <= mode_sel(nxt);
            mode_stb <= (nxt != state);
            if (!auto_en || state == MODE_IDLE || auto_cnt == AUTO_LAST) begin
                auto_cnt <= '0;
            end else begin
                auto_cnt <= auto_cnt + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + SCAN_BITS'(1);
        end
    end

    assign digit = scan_cnt[SCAN_BITS-1 -: 2];

endmodule

// File: tb/tb_cmp_mode_ctrl.sv
// tb/tb_cmp_mode_ctrl.sv - directed vector bench for cmp_mode_ctrl
module tb_cmp_mode_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       b1 = 1'b0;
    logic       b2 = 1'b0;
    logic       b3 = 1'b0;
    logic       auto_en = 1'b0;
    logic [2:0] sel;
    logic [1:0] mode;
    logic       mode_stb;
    logic [1:0] digit;

    int n_pass  = 0;
    int n_total = 0;

    cmp_mode_ctrl #(
        .DEB_CYCLES  (4),
        .AUTO_CYCLES (8),
        .SCAN_BITS   (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .b1       (b1),
        .b2       (b2),
        .b3       (b3),
        .auto_en  (auto_en),
        .sel      (sel),
        .mode     (mode),
        .mode_stb (mode_stb),
        .digit    (digit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v1;
        logic       v2;
        logic       v3;
        logic       va;
        int         cycles;
        logic [1:0] exp_mode;
        logic [2:0] exp_sel;
        int         exp_stb;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drive inputs at a negedge, run n clocks, count strobes seen at negedges.
    task automatic apply(input logic v1, input logic v2, input logic v3, input logic va,
                         input int n, output int stbs);
        b1 = v1; b2 = v2; b3 = v3; auto_en = va;
        stbs = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (mode_stb) stbs++;
        end
    endtask

    // Returns the number of rising edges until a strobe is seen, or -1 on timeout.
    task automatic wait_stb(input int max, output int edges);
        edges = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (mode_stb) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        int e;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 2'b10, 3'b010, 1};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 2'b10, 3'b010, 0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 10, 2'b10, 3'b010, 0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 2'b10, 3'b010, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 10, 2'b11, 3'b100, 1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 2'b11, 3'b100, 0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 10, 2'b00, 3'b000, 1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 2'b00, 3'b000, 0};

        repeat (3) @(negedge clk);
        check("reset_mode", int'(mode), 0);
        check("reset_sel", int'(sel), 0);
        check("reset_stb", int'(mode_stb), 0);
        check("reset_digit", int'(digit), 0);

        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("digit_%0d", i), int'(digit), (i >> 1) & 3);
        end
        check("idle_mode", int'(mode), 0);

        for (int k = 0; k < 8; k++) begin
            apply(vecs[k].v1, vecs[k].v2, vecs[k].v3, vecs[k].va, vecs[k].cycles, s);
            check($sformatf("vec%0d_mode", k), int'(mode), int'(vecs[k].exp_mode));
            check($sformatf("vec%0d_sel", k), int'(sel), int'(vecs[k].exp_sel));
            check($sformatf("vec%0d_stb", k), s, vecs[k].exp_stb);
        end

        // Clean press latency: 2 sync + 4 debounce + 1 press + 1 register.
        b2 = 1'b1;
        wait_stb(30, e);
        check("latency_b2", e, 8);
        check("latency_b2_mode", int'(mode), 2);
        apply(0, 0, 0, 0, 10, s);
        check("release_b2_stb", s, 0);
        apply(0, 1, 0, 0, 10, s);
        check("retoggle_b2_mode", int'(mode), 0);
        apply(0, 0, 0, 0, 10, s);

        // Pulse shorter than the debounce window.
        apply(0, 1, 0, 0, 3, s);
        e = s;
        apply(0, 0, 0, 0, 10, s);
        check("short_pulse_stb", e + s, 0);
        check("short_pulse_mode", int'(mode), 0);

        // Bounce 1-0-1-0 at 2-clock intervals, then held high.
        e = 0;
        apply(1, 0, 0, 0, 2, s); e += s;
        apply(0, 0, 0, 0, 2, s); e += s;
        apply(1, 0, 0, 0, 2, s); e += s;
        apply(0, 0, 0, 0, 2, s); e += s;
        check("bounce_stb", e, 0);
        b1 = 1'b1;
        wait_stb(30, e);
        check("bounce_latency", e, 8);
        check("bounce_mode", int'(mode), 1);
        check("bounce_sel", int'(sel), 3'b001);
        apply(1, 0, 0, 0, 6, s);
        e = s;
        apply(0, 0, 0, 0, 10, s);
        check("bounce_single_stb", e + s, 0);
        apply(1, 0, 0, 0, 10, s);
        check("b1_off_stb", s, 1);
        check("b1_off_mode", int'(mode), 0);
        check("b1_off_sel", int'(sel), 0);
        apply(0, 0, 0, 0, 10, s);

        // Auto-cycle from IDLE with a b3 press that must be ignored.
        auto_en = 1'b1;
        wait_stb(20, e);
        check("auto_enter", e, 1);
        check("auto_enter_mode", int'(mode), 1);
        b3 = 1'b1;
        wait_stb(20, e);
        check("auto_step_lt", e, 8);
        check("auto_lt_mode", int'(mode), 2);
        check("auto_lt_sel", int'(sel), 3'b010);
        b3 = 1'b0;
        wait_stb(20, e);
        check("auto_step_gt", e, 8);
        check("auto_gt_mode", int'(mode), 3);
        wait_stb(20, e);
        check("auto_step_eq", e, 8);
        check("auto_wrap_mode", int'(mode), 1);
        apply(0, 0, 0, 1, 3, s);
        apply(0, 0, 0, 0, 20, s);
        check("auto_drop_stb", s, 0);
        check("auto_drop_mode", int'(mode), 1);
        apply(1, 0, 0, 0, 10, s);
        check("manual_after_auto", int'(mode), 0);
        apply(0, 0, 0, 0, 10, s);

        // Reset in the middle of an auto step.
        auto_en = 1'b1;
        wait_stb(20, e);
        check("auto2_enter", e, 1);
        apply(0, 0, 0, 1, 5, s);
        reset = 1'b1;
        #1;
        check("midreset_mode", int'(mode), 0);
        check("midreset_sel", int'(sel), 0);
        check("midreset_stb", int'(mode_stb), 0);
        check("midreset_digit", int'(digit), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_stb(20, e);
        check("post_reset_enter", e, 1);
        check("post_reset_mode", int'(mode), 1);
        wait_stb(20, e);
        check("post_reset_step", e, 8);
        check("post_reset_step_mode", int'(mode), 2);
        auto_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
